switch_pio_debounce: RTL and testbench
======================================

// Module: switch_pio_debounce
// PURPOSE
//  Parametrised switch input peripheral for the SoC bus: synchronises NUM_SW raw switches,
//  debounces each channel, and exposes state, sticky edge capture and a maskable interrupt.
//  Sits between board switch pins and the CPU slave bus; replaces the plain latch-on-read switch register.
// PARAMETERS
//  NUM_SW          10     number of switch channels (1..DATA_W)
//  DATA_W          16     bus data width; channel bits zero-extended to DATA_W
//  SYNC_STAGES     2      input synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES 50000  cycles a synced input must differ from stable state before accepted (>=1)
// PORTS
//  iClk            in   1        system clock
//  iReset          in   1        asynchronous reset, active-high
//  iChip_select_n  in   1        bus chip select, active-low
//  iRead_n         in   1        bus read strobe, active-low
//  iWrite_n        in   1        bus write strobe, active-low
//  iAddress        in   2        register index
//  iWritedata      in   DATA_W   write data
//  iSwitches_data  in   NUM_SW   raw asynchronous switch pins
//  oReaddata       out  DATA_W   registered read data
//  oIrq            out  1        interrupt, level, active-high
// BEHAVIOUR
//  Reset: all sync flops, stable state, counters, EDGE, MASK, CFG, oReaddata, oIrq = 0.
//  Sync: SYNC_STAGES-flop chain per channel; sync output = last stage.
//  Debounce (per channel, counter width $clog2(DEBOUNCE_CYCLES+1)):
//   - sync == stable -> counter cleared to 0.
//   - sync != stable -> counter +1; when counter == DEBOUNCE_CYCLES-1 and still differing,
//     stable <= sync and counter <= 0 on that edge. Total pin-to-stable = SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//   - any glitch returning to stable before terminal count restarts from 0; no wrap possible.
//  Edge detect on stable: rise = 0->1, fall = 1->0; EDGE[i] set if (rise & CFG[0]) | (fall & CFG[1]).
//  Register map (access valid when ~iChip_select_n):
//   0 DATA  RO  {0, stable[NUM_SW-1:0]}
//   1 EDGE  R/W1C sticky capture; write 1 clears bit; set and clear same cycle -> set wins
//   2 MASK  RW  bits [NUM_SW-1:0]; upper bits read 0, writes ignored
//   3 CFG   RW  bit0 rising enable, bit1 falling enable; other bits read 0
//  Read: ~cs & ~rd at edge N -> oReaddata valid after edge N (1-cycle latency), held until next read.
//  Write: ~cs & ~wr at edge N -> register updated at edge N. Strobes with cs_n high ignored.
//  Read and write same cycle same address: read returns pre-write value.
//  oIrq registered: oIrq <= |(EDGE & MASK) evaluated on next-state EDGE/MASK values, i.e. asserts
//   the cycle after edge capture; deasserts the cycle after the clearing write.
//  Reset asserted mid-debounce or mid-read: everything returns to reset values immediately;
//   after release, a held-high switch is re-debounced and produces a rising edge (if enabled).
// TESTING (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_SW=10, DATA_W=16)
//  1 Reset: hold iReset 3 cycles with switches=10'h3FF -> oReaddata=0, oIrq=0; read DATA after release
//    before 6 cycles -> 0x0000; after 6 cycles -> 0x03FF.
//  2 Bounce: toggle sw0 1,0,1 every 2 cycles, then hold 1 -> DATA bit0 rises exactly 6 cycles after last toggle.
//  3 Edges: CFG=3, MASK=0x001, sw0 0->1 stable -> EDGE=0x0001, oIrq=1 next cycle; write EDGE=0x0001
//    -> EDGE=0, oIrq=0 next cycle; sw0 1->0 -> EDGE=0x0001 again.
//  4 Mask/mode: CFG=1 (rise only), MASK=0; sw3 falls -> EDGE=0; sw3 rises -> EDGE=0x0008, oIrq stays 0;
//    write MASK=0x0008 -> oIrq=1 next cycle.
//  5 Race: W1C of EDGE bit5 on same cycle as new sw5 edge capture -> EDGE bit5 remains 1.
//  6 Bus: write MASK=0xFFFF -> readback 0x03FF; write with cs_n=1 -> no change; read/write MASK
//    same cycle -> old value returned.

Source files
------------

// File: rtl/switch_pio_debounce.sv
// switch_pio_debounce: bus-mapped switch input peripheral.
// Each raw switch pin goes through a synchroniser chain and a per-channel
// debounce counter. The debounced (stable) state is readable, and its edges
// feed a sticky write-one-to-clear capture register. A mask gates that
// register into a registered level interrupt.
//
// Bus handshake: a cycle is an access only when iChip_select_n is low at the
// clock edge. With iWrite_n low, the addressed register takes iWritedata on
// that same edge. With iRead_n low, oReaddata is loaded on that edge and holds
// until the next read. If a read and a write hit the same address together,
// the read returns the value from before the write. There is no wait state and
// no back-pressure.
module switch_pio_debounce #(
   parameter int NUM_SW          = 10,
   parameter int DATA_W          = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iChip_select_n,
   input  logic              iRead_n,
   input  logic              iWrite_n,
   input  logic [1:0]        iAddress,
   input  logic [DATA_W-1:0] iWritedata,
   input  logic [NUM_SW-1:0] iSwitches_data,
   output logic [DATA_W-1:0] oReaddata,
   output logic              oIrq
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Terminal count: the channel is accepted on the edge where the counter
   // holds this value and the input still differs.
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Channel bits of a bus word. Bits above NUM_SW are never stored.
   localparam logic [DATA_W-1:0] CH_MASK  = DATA_W'({NUM_SW{1'b1}});

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_EDGE = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CFG  = 2'd3;

   // ---------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------
   logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SW-1:0] sync_d [SYNC_STAGES];
   logic [NUM_SW-1:0] sync_out;

   // Shift the raw pins down the chain; the last stage is the clean sample.
   always_comb begin
      sync_d[0] = iSwitches_data;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      sync_out = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser flops.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Debounce
   // ---------------------------------------------------------------------
   logic [NUM_SW-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q [NUM_SW];
   logic [CNT_W-1:0]  cnt_d [NUM_SW];

   // Count consecutive cycles in which a channel differs from its stable
   // state. A single cycle of agreement restarts the count. The counter never
   // passes CNT_LAST, so it cannot wrap.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_SW; i++) begin
         cnt_d[i] = '0;
         if (sync_out[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync_out[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Stable state and debounce counters.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         stable_q <= '0;
         for (int i = 0; i < NUM_SW; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < NUM_SW; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Edge capture, mask, config, read data, interrupt
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] edge_q, edge_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [1:0]        cfg_q, cfg_d;
   logic [DATA_W-1:0] readdata_q, readdata_d;
   logic              irq_q, irq_d;

   logic              wr_en, rd_en;
   logic [NUM_SW-1:0] rise, fall;
   logic [DATA_W-1:0] edge_set, edge_clr;

   // Decode the bus, detect edges on the stable state, and compute the next
   // register values. The interrupt is taken from the next-state edge and
   // mask, so it moves on the same clock as the event that causes it.
   always_comb begin
      wr_en      = ~iChip_select_n & ~iWrite_n;
      rd_en      = ~iChip_select_n & ~iRead_n;

      rise       = stable_d & ~stable_q;
      fall       = ~stable_d & stable_q;
      edge_set   = DATA_W'((rise & {NUM_SW{cfg_q[0]}}) | (fall & {NUM_SW{cfg_q[1]}}));

      mask_d     = mask_q;
      cfg_d      = cfg_q;
      edge_clr   = '0;
      if (wr_en) begin
         case (iAddress)
            ADDR_DATA: ;
            ADDR_EDGE: edge_clr = iWritedata & CH_MASK;
            ADDR_MASK: mask_d   = iWritedata & CH_MASK;
            ADDR_CFG:  cfg_d    = iWritedata[1:0];
         endcase
      end
      // A clear that coincides with a new capture loses to the capture.
      edge_d     = (edge_q & ~edge_clr) | edge_set;

      readdata_d = readdata_q;
      if (rd_en) begin
         case (iAddress)
            ADDR_DATA: readdata_d = DATA_W'(stable_q);
            ADDR_EDGE: readdata_d = edge_q;
            ADDR_MASK: readdata_d = mask_q;
            ADDR_CFG:  readdata_d = DATA_W'(cfg_q);
         endcase
      end

      irq_d      = |(edge_d & mask_d);
   end

   // Bus-visible registers.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         edge_q     <= '0;
         mask_q     <= '0;
         cfg_q      <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         edge_q     <= edge_d;
         mask_q     <= mask_d;
         cfg_q      <= cfg_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign oReaddata = readdata_q;
   assign oIrq      = irq_q;

endmodule

// File: tb/tb_switch_pio_debounce.sv
// Directed bench for switch_pio_debounce with a short debounce window.
// Each driver task starts and ends on a falling clock edge, so every bus
// strobe covers exactly one rising edge and outputs are sampled mid-cycle.
module tb_switch_pio_debounce;

   localparam int NUM_SW = 10;
   localparam int DATA_W = 16;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_EDGE = 2'd1;
   localparam logic [1:0] A_MASK = 2'd2;
   localparam logic [1:0] A_CFG  = 2'd3;

   logic              clk;
   logic              rst;
   logic              cs_n;
   logic              rd_n;
   logic              wr_n;
   logic [1:0]        addr;
   logic [DATA_W-1:0] wdata;
   logic [NUM_SW-1:0] sw;
   logic [DATA_W-1:0] rdata;
   logic              irq;

   int checks;
   int errors;
   logic [DATA_W-1:0] exp_q[$];

   switch_pio_debounce #(
      .NUM_SW(NUM_SW),
      .DATA_W(DATA_W),
      .SYNC_STAGES(2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .iClk(clk),
      .iReset(rst),
      .iChip_select_n(cs_n),
      .iRead_n(rd_n),
      .iWrite_n(wr_n),
      .iAddress(addr),
      .iWritedata(wdata),
      .iSwitches_data(sw),
      .oReaddata(rdata),
      .oIrq(irq)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
      cs_n = 1'b0; wr_n = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
   endtask

   // Write strobe with chip select deasserted: must be ignored.
   task automatic ghost_write(input logic [1:0] a, input logic [DATA_W-1:0] d);
      cs_n = 1'b1; wr_n = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      wr_n = 1'b1;
   endtask

   // Read strobe with chip select deasserted: read data must hold.
   task automatic ghost_read(input logic [1:0] a);
      cs_n = 1'b1; rd_n = 1'b0; addr = a;
      @(negedge clk);
      rd_n = 1'b1;
   endtask

   // Read one register and score it against the expected value queued first.
   task automatic read_check(input string tag, input logic [1:0] a, input logic [DATA_W-1:0] exp);
      exp_q.push_back(exp);
      cs_n = 1'b0; rd_n = 1'b0; addr = a;
      @(negedge clk);
      cs_n = 1'b1; rd_n = 1'b1;
      check(tag, rdata, exp_q.pop_front());
   endtask

   // Simultaneous read and write of one address.
   task automatic rw_check(input string tag, input logic [1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] exp);
      exp_q.push_back(exp);
      cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      check(tag, rdata, exp_q.pop_front());
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      cs_n   = 1'b1;
      rd_n   = 1'b1;
      wr_n   = 1'b1;
      addr   = '0;
      wdata  = '0;
      sw     = 10'h3FF;

      // Reset with all switches high.
      idle(3);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_irq", {15'd0, irq}, 16'h0000);
      rst = 1'b0;
      // Stable updates on the 6th edge after release; a read strobed on
      // edge 6 still sees the old state, one on edge 7 sees the new.
      idle(5);
      read_check("data_early", A_DATA, 16'h0000);
      read_check("data_settled", A_DATA, 16'h03FF);

      // Bounce on sw0: 1,0,1 two cycles apart, then held.
      sw = 10'h000;
      idle(8);
      read_check("data_low", A_DATA, 16'h0000);
      sw[0] = 1'b1;
      idle(2);
      sw[0] = 1'b0;
      idle(2);
      sw[0] = 1'b1;
      idle(5);
      read_check("bounce_early", A_DATA, 16'h0000);
      read_check("bounce_settled", A_DATA, 16'h0001);

      // Edge capture both ways on sw0 with interrupt enabled.
      sw[0] = 1'b0;
      idle(8);
      bus_write(A_CFG, 16'h0003);
      bus_write(A_MASK, 16'h0001);
      check("irq_idle", {15'd0, irq}, 16'h0000);
      read_check("edge_idle", A_EDGE, 16'h0000);
      sw[0] = 1'b1;
      idle(5);
      check("irq_before_rise", {15'd0, irq}, 16'h0000);
      idle(1);
      check("irq_rise", {15'd0, irq}, 16'h0001);
      read_check("edge_rise", A_EDGE, 16'h0001);
      bus_write(A_EDGE, 16'h0001);
      check("irq_cleared", {15'd0, irq}, 16'h0000);
      read_check("edge_cleared", A_EDGE, 16'h0000);
      sw[0] = 1'b0;
      idle(6);
      check("irq_fall", {15'd0, irq}, 16'h0001);
      read_check("edge_fall", A_EDGE, 16'h0001);
      bus_write(A_EDGE, 16'h0001);

      // Rising-only mode on sw3 with interrupt masked, then unmasked.
      bus_write(A_CFG, 16'h0000);
      sw[3] = 1'b1;
      idle(8);
      bus_write(A_CFG, 16'h0001);
      bus_write(A_MASK, 16'h0000);
      sw[3] = 1'b0;
      idle(8);
      read_check("edge_fall_ignored", A_EDGE, 16'h0000);
      sw[3] = 1'b1;
      idle(8);
      read_check("edge_rise_only", A_EDGE, 16'h0008);
      check("irq_masked", {15'd0, irq}, 16'h0000);
      bus_write(A_MASK, 16'h0008);
      check("irq_unmasked", {15'd0, irq}, 16'h0001);

      // Clear racing a new capture on sw5: the capture wins.
      bus_write(A_EDGE, 16'hFFFF);
      check("irq_w1c_all", {15'd0, irq}, 16'h0000);
      read_check("edge_w1c_all", A_EDGE, 16'h0000);
      bus_write(A_CFG, 16'h0003);
      sw[5] = 1'b1;
      idle(8);
      read_check("race_pre", A_EDGE, 16'h0020);
      sw[5] = 1'b0;
      idle(5);
      bus_write(A_EDGE, 16'h0020);
      read_check("race_set_wins", A_EDGE, 16'h0020);
      bus_write(A_EDGE, 16'h0020);
      read_check("race_after_clear", A_EDGE, 16'h0000);

      // Bus behaviour.
      bus_write(A_MASK, 16'hFFFF);
      read_check("mask_readback", A_MASK, 16'h03FF);
      ghost_write(A_MASK, 16'h0000);
      read_check("mask_cs_ignored", A_MASK, 16'h03FF);
      rw_check("rw_old_value", A_MASK, 16'h0005, 16'h03FF);
      read_check("rw_new_value", A_MASK, 16'h0005);
      bus_write(A_CFG, 16'hFFFF);
      read_check("cfg_readback", A_CFG, 16'h0003);
      idle(3);
      ghost_read(A_DATA);
      check("rdata_hold", rdata, 16'h0003);
      read_check("data_pattern", A_DATA, 16'h0008);

      // Reset mid-debounce, then the held-high switches re-debounce.
      sw = 10'h3FF;
      idle(3);
      rst = 1'b1;
      idle(2);
      check("midrst_rdata", rdata, 16'h0000);
      check("midrst_irq", {15'd0, irq}, 16'h0000);
      rst = 1'b0;
      bus_write(A_CFG, 16'h0001);
      bus_write(A_MASK, 16'h03FF);
      idle(3);
      check("midrst_irq_before", {15'd0, irq}, 16'h0000);
      idle(1);
      check("midrst_irq_rise", {15'd0, irq}, 16'h0001);
      read_check("midrst_edge", A_EDGE, 16'h03FF);
      read_check("midrst_data", A_DATA, 16'h03FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
